// File: rtl/demux_packer_pkg.sv
// demux_packer_pkg: shared slot packing helper and FILL/FULL state encoding
package demux_packer_pkg;
  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;
  function automatic int slot_base(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one packed-bus slot, a data register plus its written flag
module demux_slot #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         m
);
  // clear drops only the written flag so the data stays visible after consume
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q <= '0;
      m <= 1'b0;
    end else if (clr) begin
      m <= 1'b0;
    end else if (we) begin
      q <= d;
      m <= 1'b1;
    end
endmodule

// File: rtl/demux_packer.sv
// demux_packer: stores addressed items into a packed bus, presents it when every slot is written
module demux_packer
  import demux_packer_pkg::*;
#(
  parameter int D_SIZE  = 2,
  parameter int D_COUNT = 3,
  parameter int A_SIZE  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [D_SIZE-1:0]         in_data,
  input  logic [A_SIZE-1:0]         in_addr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  output logic [D_SIZE*D_COUNT-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [A_SIZE:0]           fill_count,
  output logic                      addr_err
);
  state_t state, next_state;
  logic [D_COUNT-1:0] mask, we;
  logic acc, bad_addr, clr;
  assign out_valid = state == FULL;
  assign in_ready  = !out_valid;
  assign acc       = in_valid && in_ready && !flush;
  assign bad_addr  = int'(in_addr) >= D_COUNT;
  assign clr       = state == FILL ? flush : out_ready;
  for (genvar k = 0; k < D_COUNT; k++) begin : g_slot
    assign we[k] = acc && in_addr == A_SIZE'(k);
    demux_slot #(.W(D_SIZE)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we[k]),
      .clr   (clr),
      .d     (in_data),
      .q     (out_data[slot_base(k, D_SIZE) +: D_SIZE]),
      .m     (mask[k])
    );
  end
  // state register and the out-of-range pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= FILL;
      addr_err <= 1'b0;
    end else begin
      state    <= next_state;
      addr_err <= acc && bad_addr;
    end
  // go FULL once this accept completes the mask; only out_ready leaves FULL
  always_comb begin
    next_state = state;
    next_state = state == FILL ? ((acc && &(mask | we)) ? FULL : FILL)
                               : (out_ready ? FILL : FULL);
  end
  // popcount of the written flags, bounded by D_COUNT by construction
  always_comb begin
    fill_count = '0;
    for (int i = 0; i < D_COUNT; i++) fill_count += (A_SIZE+1)'(mask[i]);
  end
endmodule

// File: tb/tb_demux_packer.sv
// tb_demux_packer: directed self-checking bench for demux_packer
module tb_demux_packer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] in_data = '0;
  logic [1:0] in_addr = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic [5:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] fill_count;
  logic       addr_err;
  int errors = 0;
  int checks = 0;

  demux_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_addr    (in_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_count (fill_count),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] d);
    in_addr  = a;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_fill", fill_count, 0);
    check("rst_err", addr_err, 0);
    rst_n = 1'b1;
    #1 check("rst_ready", in_ready, 1);
    @(negedge clk);
    wr(0, 2); check("t1_fill1", fill_count, 1); check("t1_nv1", out_valid, 0);
    wr(1, 1); check("t1_fill2", fill_count, 2); check("t1_nv2", out_valid, 0);
    wr(2, 3); check("t1_fill3", fill_count, 3);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 6'b11_01_10);
    in_valid = 1'b1; in_addr = 0; in_data = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_ready", in_ready, 0);
      check("t2_data", out_data, 6'b11_01_10);
    end
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t2_flush_full", out_valid, 1);
    check("t2_flush_fill", fill_count, 3);
    consume();
    check("t2_cons_valid", out_valid, 0);
    check("t2_cons_ready", in_ready, 1);
    check("t2_cons_fill", fill_count, 0);
    check("t2_cons_data", out_data, 6'b11_01_10);
    wr(1, 1); check("t3_f1", fill_count, 1);
    wr(1, 2); check("t3_f2", fill_count, 1);
    wr(0, 3); check("t3_f3", fill_count, 2);
    wr(2, 0); check("t3_f4", fill_count, 3);
    check("t3_data", out_data, 6'b00_10_11);
    check("t3_valid", out_valid, 1);
    consume();
    wr(0, 1); check("t4_pre_fill", fill_count, 1);
    check("t4_pre_err", addr_err, 0);
    wr(3, 1);
    check("t4_err", addr_err, 1);
    check("t4_fill", fill_count, 1);
    check("t4_data", out_data, 6'b00_10_01);
    @(negedge clk);
    check("t4_err_low", addr_err, 0);
    check("t4_fill2", fill_count, 1);
    check("t4_nv", out_valid, 0);
    consume();
    wr(0, 2);
    wr(1, 3); check("t5_fill2", fill_count, 2);
    flush = 1'b1; in_valid = 1'b1; in_addr = 2; in_data = 1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("t5_fill0", fill_count, 0);
    check("t5_nv", out_valid, 0);
    check("t5_data", out_data, 6'b00_11_10);
    @(negedge clk);
    check("t5_nv2", out_valid, 0);
    wr(0, 1); wr(1, 1); wr(2, 1);
    check("t5_valid", out_valid, 1);
    check("t5_refill", out_data, 6'b01_01_01);
    consume();
    wr(0, 3);
    wr(1, 2); check("t6_fill2", fill_count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_fill", fill_count, 0);
    check("t6_data", out_data, 0);
    check("t6_valid", out_valid, 0);
    check("t6_err", addr_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready", in_ready, 1);
    check("t6_fill_after", fill_count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
